// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the byte-lane data memory
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian lane mask/positioning for stores, lane extract/extend for loads
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   input  logic [31:0] dina,
   input  logic [31:0] raw_word,
   output logic [3:0]  wmask,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Mask bit i covers word bits [8i+7:8i]; offset 0 is the most significant byte.
   always_comb begin
      wmask      = 4'b0000;
      wdata      = dina;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            wmask = 4'b1000 >> offset;
            wdata = {4{dina[7:0]}};
         end
         SZ_HALF: begin
            misaligned = offset[0];
            wmask      = offset[1] ? 4'b0011 : 4'b1100;
            wdata      = {2{dina[15:0]}};
         end
         SZ_WORD: begin
            misaligned = (offset != 2'b00);
            wmask      = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      case (offset)
         2'd0:    byte_v = raw_word[31:24];
         2'd1:    byte_v = raw_word[23:16];
         2'd2:    byte_v = raw_word[15:8];
         default: byte_v = raw_word[7:0];
      endcase
      half_v = offset[1] ? raw_word[15:0] : raw_word[31:16];

      case (size)
         SZ_BYTE: load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
         SZ_HALF: load_data = {{16{sign_ext & half_v[15]}}, half_v};
         default: load_data = raw_word;
      endcase
   end

endmodule

// File: rtl/data_memory_bytelane.sv
// rtl/data_memory_bytelane.sv - MEM-stage data RAM with byte lanes, registered reads and a post-reset clear sweep
module data_memory_bytelane
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WIDTH  = 4,
   parameter int DBG_WORDS  = 10
) (
   input  logic                        clka,
   input  logic                        reset,
   input  logic                        req,
   input  logic                        we,
   input  logic [1:0]                  size,
   input  logic                        sign_ext,
   input  logic [MEM_WIDTH+1:0]        addra,
   input  logic [DATA_WIDTH-1:0]       dina,
   output logic [DATA_WIDTH-1:0]       douta,
   output logic                        rvalid,
   output logic                        misaligned,
   output logic                        busy,
   output logic [32*DBG_WORDS-1:0]     debug_words
);

   localparam int DEPTH = 2**MEM_WIDTH;
   localparam logic [MEM_WIDTH-1:0] LAST_IDX = '1;

   state_e                state_q, state_d;
   logic [MEM_WIDTH-1:0]  clr_idx_q, clr_idx_d;
   logic [DATA_WIDTH-1:0] douta_q, douta_d;
   logic                  rvalid_q, rvalid_d;
   logic                  misaligned_q, misaligned_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [MEM_WIDTH-1:0]  word_idx;
   logic [3:0]            lane_mask;
   logic [31:0]           lane_wdata;
   logic [31:0]           lane_load;
   logic                  lane_misaligned;

   logic                  mem_we;
   logic [MEM_WIDTH-1:0]  mem_idx;
   logic [3:0]            mem_mask;
   logic [31:0]           mem_wdata;

   assign word_idx = addra[MEM_WIDTH+1:2];

   mem_lane_align u_lane_align (
      .size       (size),
      .offset     (addra[1:0]),
      .sign_ext   (sign_ext),
      .dina       (dina),
      .raw_word   (mem_q[word_idx]),
      .wmask      (lane_mask),
      .wdata      (lane_wdata),
      .load_data  (lane_load),
      .misaligned (lane_misaligned)
   );

   always_comb begin
      state_d      = state_q;
      clr_idx_d    = clr_idx_q;
      douta_d      = douta_q;
      rvalid_d     = 1'b0;
      misaligned_d = 1'b0;
      mem_we       = 1'b0;
      mem_idx      = word_idx;
      mem_mask     = lane_mask;
      mem_wdata    = lane_wdata;

      if (reset) begin
         state_d   = ST_CLEAR;
         clr_idx_d = '0;
         douta_d   = '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               mem_we    = 1'b1;
               mem_idx   = clr_idx_q;
               mem_mask  = 4'b1111;
               mem_wdata = '0;
               clr_idx_d = clr_idx_q + MEM_WIDTH'(1);
               if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
            end
            default: begin
               if (req) begin
                  if (lane_misaligned) begin
                     misaligned_d = 1'b1;
                     if (!we) douta_d = '0;
                  end else if (we) begin
                     mem_we = 1'b1;
                  end else begin
                     douta_d  = lane_load;
                     rvalid_d = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clka) begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      douta_q      <= douta_d;
      rvalid_q     <= rvalid_d;
      misaligned_q <= misaligned_d;
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_mask[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   // mem[0] lands in the most significant slot of the debug bus.
   for (genvar i = 0; i < DBG_WORDS; i++) begin : g_dbg
      assign debug_words[32*(DBG_WORDS-1-i) +: 32] = mem_q[i];
   end

   assign douta      = douta_q;
   assign rvalid     = rvalid_q;
   assign misaligned = misaligned_q;
   assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb/tb_data_memory_bytelane.sv - directed self-checking bench for data_memory_bytelane
module tb_data_memory_bytelane;

   logic         clka = 1'b0;
   logic         reset = 1'b0;
   logic         req = 1'b0;
   logic         we = 1'b0;
   logic [1:0]   size = 2'b00;
   logic         sign_ext = 1'b0;
   logic [5:0]   addra = '0;
   logic [31:0]  dina = '0;
   logic [31:0]  douta;
   logic         rvalid;
   logic         misaligned;
   logic         busy;
   logic [319:0] debug_words;

   int errors = 0;
   int checks = 0;

   data_memory_bytelane #(.DATA_WIDTH(32), .MEM_WIDTH(4), .DBG_WORDS(10)) dut (
      .clka        (clka),
      .reset       (reset),
      .req         (req),
      .we          (we),
      .size        (size),
      .sign_ext    (sign_ext),
      .addra       (addra),
      .dina        (dina),
      .douta       (douta),
      .rvalid      (rvalid),
      .misaligned  (misaligned),
      .busy        (busy),
      .debug_words (debug_words)
   );

   always #5 clka = ~clka;

   task automatic cycle();
      @(posedge clka);
      #1;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [5:0] a, input logic [31:0] d);
      req = 1'b1; we = w; size = sz; sign_ext = sx; addra = a; dina = d;
      cycle();
      req = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         cycle();
      end
   endtask

   task automatic test_reset();
      int n;
      logic stray;
      reset = 1'b1; cycle(); reset = 1'b0;
      checks++; if (douta !== 32'h0 || rvalid !== 1'b0 || misaligned !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL reset_state: douta=%h rvalid=%b mis=%b busy=%b expected 0/0/0/1", douta, rvalid, misaligned, busy);
      end
      count_busy(n);
      checks++; if (n !== 16) begin errors++; $display("FAIL first_sweep_len: got %0d expected 16", n); end
      for (int i = 0; i < 16; i++) issue(1'b1, 2'b10, 1'b0, 6'(i*4), 32'hA5A50000 + 32'(i));
      reset = 1'b1; cycle(); reset = 1'b0;
      n = 0; stray = 1'b0;
      while (busy && n < 40) begin
         if (n == 3) begin
            req = 1'b1; we = 1'b1; size = 2'b10; addra = 6'd12; dina = 32'h55555555;
         end else begin
            req = 1'b0;
         end
         n++;
         cycle();
         if (rvalid !== 1'b0 || misaligned !== 1'b0) stray = 1'b1;
      end
      req = 1'b0;
      checks++; if (n !== 16) begin errors++; $display("FAIL sweep_len: got %0d expected 16", n); end
      checks++; if (stray !== 1'b0) begin errors++; $display("FAIL busy_req_pulse: got %b expected 0", stray); end
      checks++; if (debug_words !== 320'h0) begin errors++; $display("FAIL debug_cleared: got %h expected 0", debug_words); end
      for (int i = 0; i < 16; i++) begin
         issue(1'b0, 2'b10, 1'b0, 6'(i*4), 32'h0);
         checks++; if (douta !== 32'h0 || rvalid !== 1'b1) begin
            errors++; $display("FAIL cleared_word%0d: douta=%h rvalid=%b expected 00000000/1", i, douta, rvalid);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      reset = 1'b1; cycle(); reset = 1'b0;
      repeat (7) cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      count_busy(n);
      checks++; if (n !== 16) begin errors++; $display("FAIL mid_sweep_len: got %0d expected 16", n); end
   endtask

   task automatic test_bytes();
      issue(1'b1, 2'b10, 1'b0, 6'd0, 32'h11223344);
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL store_rvalid: got %b expected 0", rvalid); end
      issue(1'b1, 2'b00, 1'b0, 6'd2, 32'h000000AA);
      issue(1'b0, 2'b10, 1'b0, 6'd0, 32'h0);
      checks++; if (douta !== 32'h1122AA44 || rvalid !== 1'b1) begin
         errors++; $display("FAIL lw_after_sb: douta=%h rvalid=%b expected 1122aa44/1", douta, rvalid);
      end
      cycle();
      checks++; if (douta !== 32'h1122AA44 || rvalid !== 1'b0) begin
         errors++; $display("FAIL douta_hold: douta=%h rvalid=%b expected 1122aa44/0", douta, rvalid);
      end
      issue(1'b0, 2'b00, 1'b1, 6'd2, 32'h0);
      checks++; if (douta !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb: got %h expected ffffffaa", douta); end
      issue(1'b0, 2'b00, 1'b0, 6'd2, 32'h0);
      checks++; if (douta !== 32'h000000AA) begin errors++; $display("FAIL lbu: got %h expected 000000aa", douta); end
      issue(1'b0, 2'b00, 1'b0, 6'd3, 32'h0);
      checks++; if (douta !== 32'h00000044) begin errors++; $display("FAIL lbu_off3: got %h expected 00000044", douta); end
   endtask

   task automatic test_halfword();
      issue(1'b1, 2'b10, 1'b0, 6'd4, 32'h12345678);
      issue(1'b1, 2'b01, 1'b0, 6'd6, 32'h00008001);
      issue(1'b0, 2'b01, 1'b1, 6'd6, 32'h0);
      checks++; if (douta !== 32'hFFFF8001) begin errors++; $display("FAIL lh: got %h expected ffff8001", douta); end
      issue(1'b0, 2'b01, 1'b0, 6'd6, 32'h0);
      checks++; if (douta !== 32'h00008001) begin errors++; $display("FAIL lhu: got %h expected 00008001", douta); end
      issue(1'b0, 2'b01, 1'b1, 6'd4, 32'h0);
      checks++; if (douta !== 32'h00001234) begin errors++; $display("FAIL lh_off0: got %h expected 00001234", douta); end
      issue(1'b0, 2'b10, 1'b1, 6'd4, 32'h0);
      checks++; if (douta !== 32'h12348001) begin errors++; $display("FAIL lw_after_sh: got %h expected 12348001", douta); end
   endtask

   task automatic test_misaligned();
      issue(1'b0, 2'b10, 1'b0, 6'd1, 32'h0);
      checks++; if (misaligned !== 1'b1 || rvalid !== 1'b0 || douta !== 32'h0) begin
         errors++; $display("FAIL lw_mis: mis=%b rvalid=%b douta=%h expected 1/0/00000000", misaligned, rvalid, douta);
      end
      cycle();
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", misaligned); end
      issue(1'b1, 2'b01, 1'b0, 6'd3, 32'h0000BEEF);
      checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL sh_mis: got %b expected 1", misaligned); end
      issue(1'b0, 2'b10, 1'b0, 6'd0, 32'h0);
      checks++; if (douta !== 32'h1122AA44) begin errors++; $display("FAIL sh_mis_nowrite: got %h expected 1122aa44", douta); end
      issue(1'b0, 2'b11, 1'b0, 6'd0, 32'h0);
      checks++; if (misaligned !== 1'b1 || rvalid !== 1'b0) begin
         errors++; $display("FAIL size11: mis=%b rvalid=%b expected 1/0", misaligned, rvalid);
      end
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 2'b10, 1'b0, 6'd48, 32'hDEADBEEF);
      issue(1'b0, 2'b10, 1'b0, 6'd48, 32'h0);
      checks++; if (douta !== 32'hDEADBEEF || rvalid !== 1'b1) begin
         errors++; $display("FAIL raw_b2b: douta=%h rvalid=%b expected deadbeef/1", douta, rvalid);
      end
      issue(1'b1, 2'b10, 1'b0, 6'd36, 32'hCAFEF00D);
      checks++; if (debug_words[31:0] !== 32'hCAFEF00D) begin
         errors++; $display("FAIL dbg_word9: got %h expected cafef00d", debug_words[31:0]);
      end
      checks++; if (debug_words[319:288] !== 32'h1122AA44) begin
         errors++; $display("FAIL dbg_word0: got %h expected 1122aa44", debug_words[319:288]);
      end
      checks++; if (debug_words[287:256] !== 32'h12348001) begin
         errors++; $display("FAIL dbg_word1: got %h expected 12348001", debug_words[287:256]);
      end
   endtask

   initial begin
      cycle();
      test_reset();
      test_reset_mid_sweep();
      test_bytes();
      test_halfword();
      test_misaligned();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
